// File: rtl/rom_region_loader.sv
// rom_region_loader: maps download bytes to region/channel addresses, packs them into words
// and issues completed words from a FIFO on a channel-tagged req/ack write port.
module rom_region_loader #(
    parameter int NUM_REGIONS = 9,
    parameter int NUM_CHANNELS = 4,
    parameter int ADDR_W = 27,
    parameter int WORD_BYTES = 2,
    parameter int FIFO_DEPTH = 8,
    localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
    parameter logic [NUM_REGIONS*32-1:0] REGION_BASE = {
        32'h0040_0000, 32'h0000_0000, 32'h0080_0000, 32'h00A0_0000, 32'h0080_0000,
        32'h0060_0000, 32'h3810_0000, 32'h00C0_0000, 32'h0000_0000},
    parameter logic [NUM_REGIONS*CH_W-1:0] REGION_CH = {
        2'd0, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd2, 2'd0, 2'd0}
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    dl_active,
    input  logic [7:0]              dl_index,
    input  logic [ADDR_W-1:0]       dl_addr,
    input  logic [7:0]              dl_data,
    input  logic                    dl_wr,
    output logic                    dl_wait,
    output logic                    wr_req,
    output logic [CH_W-1:0]         wr_ch,
    output logic [31:0]             wr_addr,
    output logic [WORD_BYTES*8-1:0] wr_data,
    output logic [WORD_BYTES-1:0]   wr_be,
    input  logic                    wr_ack,
    output logic                    load_done,
    output logic [15:0]             drop_count
);
    localparam int WW = WORD_BYTES * 8;
    localparam int LW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {IDLE, LOAD, FLUSH, DRAIN, DONE} state_t;

    state_t                r_state;
    logic                  r_av;
    logic [31:0]           r_aaddr;
    logic [CH_W-1:0]       r_ach;
    logic [WW-1:0]         r_adata;
    logic [WORD_BYTES-1:0] r_abe;
    logic [15:0]           r_drop;
    logic [CH_W-1:0]       r_fch   [FIFO_DEPTH];
    logic [31:0]           r_faddr [FIFO_DEPTH];
    logic [WW-1:0]         r_fdata [FIFO_DEPTH];
    logic [WORD_BYTES-1:0] r_fbe   [FIFO_DEPTH];
    logic [PW-1:0]         r_wp, r_rp;
    logic [CW-1:0]         r_cnt;

    logic                  w_req, w_pop, w_room, w_byte, w_hit, w_miss, w_full;
    logic                  w_want, w_push, w_drop, w_held;
    logic [7:0]            w_idx;
    logic [31:0]           w_off, w_waddr, w_paddr;
    logic [LW-1:0]         w_lane;
    logic [CH_W-1:0]       w_ch, w_pch;
    logic [WW-1:0]         w_ndata, w_mdata, w_pdata;
    logic [WORD_BYTES-1:0] w_nbe, w_mbe, w_pbe;

    always_comb begin
        w_req = r_cnt != '0;
        w_pop = w_req & wr_ack;
        w_room = (r_cnt < CW'(FIFO_DEPTH)) | w_pop;
        w_byte = (r_state == LOAD) & dl_wr;
        w_hit = 32'(dl_index) < NUM_REGIONS;
        w_idx = w_hit ? dl_index : '0;
        w_off = 32'(dl_addr);
        w_lane = LW'(w_off) & LW'(WORD_BYTES - 1);
        w_waddr = REGION_BASE[32*w_idx +: 32] + (w_off & ~32'(WORD_BYTES - 1));
        w_ch = REGION_CH[CH_W*w_idx +: CH_W];
        w_miss = r_av & ((w_waddr != r_aaddr) | (w_ch != r_ach));
        w_ndata = '0;
        w_ndata[w_lane*8 +: 8] = dl_data;
        w_nbe = WORD_BYTES'(1) << w_lane;
        w_mdata = r_av ? r_adata : '0;
        w_mdata[w_lane*8 +: 8] = dl_data;
        w_mbe = (r_av ? r_abe : '0) | w_nbe;
        w_full = &w_mbe;
        w_want = (w_byte & w_hit & (w_miss | w_full)) | ((r_state == FLUSH) & r_av);
        w_push = w_want & w_room;
        // a byte that cannot push is lost together with the word it would have pushed
        w_drop = w_byte & (~w_hit | (w_want & ~w_room));
        w_held = (r_state == FLUSH) | w_miss;
        w_pch = w_held ? r_ach : w_ch;
        w_paddr = w_held ? r_aaddr : w_waddr;
        w_pdata = w_held ? r_adata : w_mdata;
        w_pbe = w_held ? r_abe : w_mbe;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_av <= 1'b0;
            r_aaddr <= '0;
            r_ach <= '0;
            r_adata <= '0;
            r_abe <= '0;
            r_drop <= '0;
        end else begin
            if (w_drop && r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;
            case (r_state)
                IDLE: if (dl_active) begin
                    r_state <= LOAD;
                    r_av <= 1'b0;
                    r_drop <= '0;
                end
                LOAD: begin
                    if (w_byte && w_hit) begin
                        r_av <= (w_want && !w_room) ? 1'b0 : (w_miss | ~w_full);
                        r_aaddr <= w_waddr;
                        r_ach <= w_ch;
                        r_adata <= w_miss ? w_ndata : w_mdata;
                        r_abe <= w_miss ? w_nbe : w_mbe;
                    end
                    if (!dl_active) r_state <= FLUSH;
                end
                FLUSH: if (!r_av || w_room) begin
                    r_av <= 1'b0;
                    r_state <= DRAIN;
                end
                DRAIN: if (!w_req) r_state <= DONE;
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wp <= '0;
            r_rp <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop) r_rp <= r_rp + 1'b1;
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fch[r_wp] <= w_pch;
            r_faddr[r_wp] <= w_paddr;
            r_fdata[r_wp] <= w_pdata;
            r_fbe[r_wp] <= w_pbe;
        end
    end

    // head entry is gated so every write output reads zero while the FIFO is empty
    assign wr_req = w_req;
    assign wr_ch = w_req ? r_fch[r_rp] : '0;
    assign wr_addr = w_req ? r_faddr[r_rp] : '0;
    assign wr_data = w_req ? r_fdata[r_rp] : '0;
    assign wr_be = w_req ? r_fbe[r_rp] : '0;
    assign dl_wait = (r_cnt >= CW'(FIFO_DEPTH - 1)) | (r_state != IDLE && r_state != LOAD);
    assign load_done = r_state == DONE;
    assign drop_count = r_drop;
endmodule

// File: tb/tb_rom_region_loader.sv
// tb_rom_region_loader: directed and randomized download sequences checked against a
// byte-level reference model of the region map, word packer and write queue.
module tb_rom_region_loader;
    localparam int WB = 2;
    localparam int DEPTH = 8;

    typedef struct packed {
        logic [1:0]  ch;
        logic [31:0] addr;
        logic [15:0] data;
        logic [1:0]  be;
    } word_t;

    logic        clk = 0, reset_n = 0, dl_active = 0, dl_wr = 0, wr_ack = 0;
    logic [7:0]  dl_index = 0, dl_data = 0;
    logic [26:0] dl_addr = 0;
    logic        dl_wait, wr_req, load_done;
    logic [1:0]  wr_ch, wr_be;
    logic [31:0] wr_addr;
    logic [15:0] wr_data, drop_count;

    rom_region_loader dut (
        .clk(clk), .reset_n(reset_n), .dl_active(dl_active), .dl_index(dl_index),
        .dl_addr(dl_addr), .dl_data(dl_data), .dl_wr(dl_wr), .dl_wait(dl_wait),
        .wr_req(wr_req), .wr_ch(wr_ch), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .wr_ack(wr_ack), .load_done(load_done), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0, ack_mode = 0;
    word_t exp_q[$];
    logic [31:0] base_tab [9] = '{32'h0000_0000, 32'h00C0_0000, 32'h3810_0000, 32'h0060_0000,
        32'h0080_0000, 32'h00A0_0000, 32'h0080_0000, 32'h0000_0000, 32'h0040_0000};
    int ch_tab [9] = '{0, 0, 2, 0, 0, 0, 1, 1, 0};

    bit          m_av;
    logic [31:0] m_addr;
    int          m_ch, m_drop;
    logic [7:0]  m_bytes [WB];
    bit          m_be [WB];

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic word_t m_word();
        word_t w;
        w.ch = 2'(m_ch);
        w.addr = m_addr;
        w.data = '0;
        w.be = '0;
        for (int k = 0; k < WB; k++) if (m_be[k]) begin
            w.data[8*k +: 8] = m_bytes[k];
            w.be[k] = 1'b1;
        end
        return w;
    endfunction

    function automatic bit m_push(word_t w);
        if (exp_q.size() < DEPTH) begin
            exp_q.push_back(w);
            return 1;
        end
        if (m_drop < 65535) m_drop++;
        return 0;
    endfunction

    function automatic void m_start(logic [31:0] a, int ch, int lane, logic [7:0] d);
        m_av = 1;
        m_addr = a;
        m_ch = ch;
        for (int k = 0; k < WB; k++) begin
            m_bytes[k] = 8'h00;
            m_be[k] = 0;
        end
        m_bytes[lane] = d;
        m_be[lane] = 1;
    endfunction

    function automatic void m_byte(int idx, int addr, logic [7:0] d);
        logic [31:0] wa;
        int lane, ch;
        bit all;
        if (idx >= 9) begin
            if (m_drop < 65535) m_drop++;
            return;
        end
        wa = base_tab[idx] + 32'((addr / WB) * WB);
        lane = addr % WB;
        ch = ch_tab[idx];
        if (m_av && (wa != m_addr || ch != m_ch)) begin
            if (m_push(m_word())) m_start(wa, ch, lane, d);
            else m_av = 0;
        end else begin
            if (!m_av) m_start(wa, ch, lane, d);
            else begin
                m_bytes[lane] = d;
                m_be[lane] = 1;
            end
            all = 1;
            for (int k = 0; k < WB; k++) all &= m_be[k];
            if (all) begin
                void'(m_push(m_word()));
                m_av = 0;
            end
        end
    endfunction

    // write-port agent: acks per ack_mode, checks hold stability and scores accepted words
    word_t prev;
    bit pend = 0;
    always @(negedge clk) begin
        word_t obs;
        obs = {wr_ch, wr_addr, wr_data, wr_be};
        if (!reset_n) begin
            pend = 0;
            wr_ack = 0;
        end else begin
            if (pend) check("hold_stable", {wr_req, obs}, {1'b1, prev});
            wr_ack = (ack_mode == 2) || (ack_mode == 1 && $urandom_range(0, 1) == 1);
            pend = wr_req && !wr_ack;
            prev = obs;
            if (wr_req && wr_ack) begin
                check("write_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) check("write_word", obs, exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic send(int idx, int addr, logic [7:0] d, bit obey);
        int t = 0;
        if (obey) begin
            while (dl_wait && t < 1000) begin
                step();
                t++;
            end
            if (dl_wait) check("wait_bound", dl_wait, 0);
        end
        dl_index = 8'(idx);
        dl_addr = 27'(addr);
        dl_data = d;
        dl_wr = 1;
        m_byte(idx, addr, d);
        step();
        dl_wr = 0;
    endtask

    task automatic begin_dl();
        dl_active = 1;
        m_av = 0;
        m_drop = 0;
        step();
    endtask

    task automatic end_dl();
        int t = 0;
        bit done = 0;
        dl_active = 0;
        if (m_av) begin
            exp_q.push_back(m_word());
            m_av = 0;
        end
        while (!done && t < 2000) begin
            step();
            t++;
            done = load_done;
        end
        check("done_seen", done, 1);
        check("done_latency", t >= 2, 1);
        check("drained", exp_q.size(), 0);
        check("drop_count", drop_count, m_drop);
        step();
        check("done_pulse", load_done, 0);
        check("idle_wait", dl_wait, 0);
    endtask

    initial begin
        int idx, addr, r;
        bit seen;
        repeat (3) @(negedge clk);
        #1;
        check("rst_wr_req", wr_req, 0);
        check("rst_dl_wait", dl_wait, 0);
        check("rst_drop", drop_count, 0);
        check("rst_done", load_done, 0);
        reset_n = 1;

        begin_dl();
        ack_mode = 0;
        send(0, 0, 8'h11, 1);
        check("latency_before", wr_req, 0);
        send(0, 1, 8'h22, 1);
        check("latency_after", wr_req, 1);
        ack_mode = 2;
        send(0, 2, 8'h33, 1);
        send(0, 3, 8'h44, 1);
        end_dl();

        begin_dl();
        send(6, 5, 8'hAA, 1);
        end_dl();

        begin_dl();
        ack_mode = 0;
        for (int i = 0; i < 14; i++) begin
            send(0, i, 8'($urandom), 1);
            check("bp_wait", dl_wait, exp_q.size() >= 7);
        end
        ack_mode = 2;
        for (int i = 14; i < 20; i++) send(0, i, 8'($urandom), 1);
        end_dl();

        begin_dl();
        ack_mode = 1;
        for (int i = 0; i < 3; i++) send(9, i, 8'($urandom), 1);
        check("invalid_no_req", wr_req, 0);
        end_dl();

        begin_dl();
        send(0, 0, 8'h5A, 1);
        send(0, 10, 8'h6B, 1);
        end_dl();

        begin_dl();
        ack_mode = 0;
        for (int i = 0; i < 20; i++) send(0, i, 8'($urandom), 0);
        check("overflow_drop", drop_count, m_drop);
        ack_mode = 2;
        end_dl();

        for (int run = 0; run < 4; run++) begin
            begin_dl();
            ack_mode = 1;
            idx = $urandom_range(0, 8);
            addr = 0;
            for (int i = 0; i < 60; i++) begin
                r = $urandom_range(0, 15);
                if (r == 0) idx = $urandom_range(0, 9);
                else if (r < 3) addr = $urandom_range(0, 63);
                else if (r != 3) addr++;
                send(idx, addr, 8'($urandom), 1);
                repeat ($urandom_range(0, 2)) step();
            end
            end_dl();
        end

        begin_dl();
        ack_mode = 0;
        send(9, 0, 8'h01, 1);
        send(0, 0, 8'h12, 1);
        send(0, 1, 8'h34, 1);
        dl_active = 0;
        repeat (4) step();
        check("rd_pending", wr_req, 1);
        check("rd_drop_before", drop_count, 1);
        reset_n = 0;
        #1;
        check("rd_wr_req", wr_req, 0);
        check("rd_wr_fields", {wr_ch, wr_addr, wr_data, wr_be}, 0);
        check("rd_dl_wait", dl_wait, 0);
        check("rd_done", load_done, 0);
        check("rd_drop", drop_count, 0);
        exp_q.delete();
        m_av = 0;
        repeat (2) step();
        reset_n = 1;
        seen = 0;
        repeat (10) begin
            step();
            if (load_done) seen = 1;
        end
        check("rd_no_done", seen, 0);
        check("rd_idle", dl_wait, 0);
        ack_mode = 1;
        begin_dl();
        send(3, 0, 8'hC3, 1);
        send(3, 1, 8'h3C, 1);
        send(3, 4, 8'h77, 1);
        end_dl();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/rom_region_loader.md
# rom_region_loader

Parametrised ROM download router that sits between the HPS download stream and the storage back-ends. It maps each download byte to a region through a parameter table of base address and storage channel, then packs bytes into WORD_BYTES-wide words. Completed words are buffered in a FIFO and issued on a single channel-tagged write port with a req/ack handshake. Unlike the fixed nine-entry load map, region count, channel count, word width and buffer depth are all parameters, and the block adds backpressure, partial-word flush and drop accounting.

## Interface
Reset is asynchronous and active-low; the block uses one clock.

Parameters:
- NUM_REGIONS, 9, number of entries in the region table.
- NUM_CHANNELS, 4, number of storage channels. Channel codes: 0 SDR_CH1, 1 SDR_CH2, 2 DDR, 3 BLOCK.
- ADDR_W, 27, width of the byte offset within a region.
- WORD_BYTES, 2, output word size. Legal values are 1, 2, 4 or 8.
- FIFO_DEPTH, 8, word FIFO depth. Must be a power of 2 and at least 2.
- REGION_BASE, default is the current F2 map, flattened as NUM_REGIONS×32 bits with entry i at [32i+31:32i]:
  - 0x0000_0000, 0x00C0_0000, 0x3810_0000, 0x0060_0000, 0x0080_0000
  - 0x00A0_0000, 0x0080_0000, 0x0000_0000, 0x0040_0000
- REGION_CH, default {0,0,2,0,0,0,1,1,0}, flattened as NUM_REGIONS×CH_W bits, where CH_W = max(1, clog2(NUM_CHANNELS)).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- dl_active  in  1  high for the whole download
- dl_index  in  8  region index
- dl_addr  in  ADDR_W  byte offset within the region
- dl_data  in  8  download byte
- dl_wr  in  1  one-cycle byte strobe
- dl_wait  out  1  host must hold off dl_wr while high
- wr_req  out  1  write request
- wr_ch  out  CH_W  target channel
- wr_addr  out  32  byte address, WORD_BYTES-aligned
- wr_data  out  WORD_BYTES×8  write data; lane k = byte k (little-endian)
- wr_be  out  WORD_BYTES  byte enables
- wr_ack  in  1  write accepted
- load_done  out  1  one-cycle pulse when the download has fully drained
- drop_count  out  16  saturating count of discarded bytes

## Operation
- States: IDLE, LOAD, FLUSH, DRAIN, DONE.
- IDLE → LOAD on dl_active high. On entry: drop_count cleared, assembler invalidated.
- In LOAD, each dl_wr byte is processed as follows:
  - If dl_index ≥ NUM_REGIONS, the byte is dropped and drop_count increments.
  - Otherwise: waddr = REGION_BASE[idx] + (dl_addr with the low log2(WORD_BYTES) bits cleared), computed mod 2^32; lane = the low bits of dl_addr; ch = REGION_CH[idx].
  - If the assembler is valid and (waddr, ch) differs from its held word, the held word is pushed and a new word is started at lane.
  - Otherwise the byte is merged into the held word and its be bit is set. A later write to the same lane overwrites the byte.
  - When all be bits are set, the word is pushed and the assembler is invalidated.
  - A byte causes at most one push.
- A push into a full FIFO discards that byte together with any word being pushed; drop_count increments by 1.
- LOAD → FLUSH on dl_active falling. FLUSH pushes a valid partial assembler word, waiting while the FIFO is full, then moves to DRAIN.
- DRAIN → DONE once the FIFO is empty and no request is outstanding. DONE pulses load_done and returns to IDLE.
- dl_wr outside LOAD is ignored and not counted.
- dl_active rising during FLUSH, DRAIN or DONE is honoured only on return to IDLE.
- REGION_BASE entries must be WORD_BYTES-aligned; this is the integrator's responsibility.

## Timing
- Reset: all outputs 0, FIFO empty, assembler invalid, state IDLE. Reset takes effect immediately, including mid-drain; pending words are lost and no load_done is generated.
- dl_wait = (FIFO count ≥ FIFO_DEPTH−1) OR state ∈ {FLUSH, DRAIN, DONE}. It is combinational from registered state.
- Latency: the byte completing a word at cycle N, with the FIFO empty, gives wr_req high at N+1.
- Handshake:
  - wr_req, wr_ch, wr_addr, wr_data and wr_be are stable until a cycle with wr_req & wr_ack.
  - The next entry appears the following cycle, so sustained throughput is 1 word/cycle.
  - wr_ack without wr_req is ignored.
- A push and a pop in the same cycle leave the count unchanged and are legal when the FIFO is full.
- drop_count saturates at 0xFFFF.
- load_done occurs at least 2 cycles after dl_active falls.

## Test plan
- Packing. Setup: WORD_BYTES=2, region 0, bytes 11,22,33,44 at addr 0..3. Required: two writes, ch0 addr 0 data 0x2211 be 11, then addr 2 data 0x4433 be 11.
- Partial flush. Setup: region 6, single byte 0xAA at addr 5, then dl_active falls. Required: write ch1 addr 0x0080_0004 data 0xAA00 be 10, ack, then load_done for one cycle.
- Backpressure. Setup: wr_ack held low, 20 sequential bytes to region 0, host obeys dl_wait. Required: dl_wait rises at FIFO count 7; after releasing ack, 10 words in address order and drop_count=0.
- Invalid region. Setup: 3 bytes with dl_index=9. Required: no wr_req, drop_count=3.
- Address jump. Setup: byte 0x5A at addr 0, then 0x6B at addr 10, then end of download. Required: write addr 0 data 0x005A be 01, then addr 10 data 0x006B be 01.
- Reset mid-drain. Setup: assert reset_n=0 while wr_req is pending. Required: all outputs 0 in the same cycle, no load_done, and state IDLE after release.
